// File: rtl/spi_slave_shifter.sv
// SPI responder shift engine: synchronises SCLK/SS_N/MOSI into pclk, handles all CPOL/CPHA modes.
// Optional SPI_SLAVE_OVERRUN_EN adds rx_ack_i / rx_overrun_o for unread-byte tracking.
module spi_slave_shifter #(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] UNDERRUN_VAL = 8'hFF
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic              rx_ack_i,
  output logic              rx_overrun_o,
`endif
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              busy_o,
  output logic              underrun_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t             r_state;
  logic               r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic               r_ss_s1, r_ss_s2;
  logic               r_mosi_s1, r_mosi_s2;
  logic               r_cpol, r_cpha, r_lsbfe;
  logic [DATA_W-1:0]  r_tx_sr, r_rx_sr, r_tx_buf, r_rx_data;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_tx_full;
  logic               r_rx_valid, r_miso, r_miso_oe, r_busy, r_underrun;
  logic               r_hold, r_reload_pend;

  logic               w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_sample, w_shift;
  logic [DATA_W-1:0]  w_rx_next, w_reload_val, w_tx_adv;
  logic               w_reload_bit, w_adv_bit, w_byte_done;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall  = ~r_sclk_s2 & r_sclk_s3;
  assign w_lead       = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail      = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample     = r_cpha ? w_trail : w_lead;
  assign w_shift      = r_cpha ? w_lead : w_trail;
  assign w_rx_next    = r_lsbfe ? {r_mosi_s2, r_rx_sr[DATA_W-1:1]} : {r_rx_sr[DATA_W-2:0], r_mosi_s2};
  assign w_reload_val = r_tx_full ? r_tx_buf : UNDERRUN_VAL;
  assign w_reload_bit = r_lsbfe ? w_reload_val[0] : w_reload_val[DATA_W-1];
  assign w_tx_adv     = r_lsbfe ? {1'b0, r_tx_sr[DATA_W-1:1]} : {r_tx_sr[DATA_W-2:0], 1'b0};
  assign w_adv_bit    = r_lsbfe ? r_tx_sr[1] : r_tx_sr[DATA_W-2];
  assign w_cnt_inc    = r_bit_cnt + CNT_W'(1);
  assign w_byte_done  = w_sample && (w_cnt_inc == CNT_W'(DATA_W));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state       <= ST_IDLE;
      r_sclk_s1     <= 1'b0;
      r_sclk_s2     <= 1'b0;
      r_sclk_s3     <= 1'b0;
      r_ss_s1       <= 1'b1;
      r_ss_s2       <= 1'b1;
      r_mosi_s1     <= 1'b0;
      r_mosi_s2     <= 1'b0;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_lsbfe       <= 1'b0;
      r_tx_sr       <= '0;
      r_rx_sr       <= '0;
      r_tx_buf      <= '0;
      r_rx_data     <= '0;
      r_bit_cnt     <= '0;
      r_tx_full     <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_busy        <= 1'b0;
      r_underrun    <= 1'b0;
      r_hold        <= 1'b0;
      r_reload_pend <= 1'b0;
    end else begin
      r_sclk_s1  <= sclk_i;
      r_sclk_s2  <= r_sclk_s1;
      r_sclk_s3  <= r_sclk_s2;
      r_ss_s1    <= ss_n_i;
      r_ss_s2    <= r_ss_s1;
      r_mosi_s1  <= mosi_i;
      r_mosi_s2  <= r_mosi_s1;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (tx_load_i && !r_tx_full) begin
        r_tx_buf  <= tx_data_i;
        r_tx_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_miso_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_bit_cnt <= '0;
          if (!r_ss_s2) begin
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_lsbfe <= lsbfe_i;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_tx_sr <= w_reload_val;
          r_miso  <= w_reload_bit;
          if (r_tx_full) r_tx_full <= 1'b0;
          else           r_underrun <= 1'b1;
          r_bit_cnt     <= '0;
          r_rx_sr       <= '0;
          r_miso_oe     <= 1'b1;
          r_busy        <= 1'b1;
          // With CPHA=1 the first leading edge must keep the bit LOAD already presented.
          r_hold        <= r_cpha;
          r_reload_pend <= 1'b0;
          r_state       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_sample) begin
            r_rx_sr <= w_rx_next;
            if (w_byte_done) begin
              r_rx_data     <= w_rx_next;
              r_rx_valid    <= 1'b1;
              r_bit_cnt     <= '0;
              r_reload_pend <= 1'b1;
            end else begin
              r_bit_cnt <= w_cnt_inc;
            end
          end else if (w_shift) begin
            // Next-byte reload waits for the shift edge so a frame ending here never consumes the buffer.
            if (r_reload_pend) begin
              r_tx_sr <= w_reload_val;
              r_miso  <= w_reload_bit;
              if (r_tx_full) r_tx_full <= 1'b0;
              else           r_underrun <= 1'b1;
              r_reload_pend <= 1'b0;
            end else if (r_hold) begin
              r_hold <= 1'b0;
            end else begin
              r_tx_sr <= w_tx_adv;
              r_miso  <= w_adv_bit;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (r_ss_s2 && (r_state != ST_IDLE)) begin
        r_state       <= ST_IDLE;
        r_miso_oe     <= 1'b0;
        r_busy        <= 1'b0;
        r_bit_cnt     <= '0;
        r_hold        <= 1'b0;
        r_reload_pend <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_unread, r_overrun;
  logic w_rx_done;

  assign w_rx_done = (r_state == ST_SHIFT) && w_byte_done;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_unread  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_rx_done) begin
      r_unread <= 1'b1;
      if (rx_ack_i)      r_overrun <= 1'b0;
      else if (r_unread) r_overrun <= 1'b1;
    end else if (rx_ack_i) begin
      r_unread  <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign rx_overrun_o = r_overrun;
`endif

  assign tx_ready_o = ~r_tx_full;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign miso_o     = r_miso;
  assign miso_oe_o  = r_miso_oe;
  assign busy_o     = r_busy;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Scoreboard bench for spi_slave_shifter: a behavioural SPI master drives frames,
// expected RX/MISO bytes are queued at stimulus time and popped as the DUT produces them.
module tb_spi_slave_shifter;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       sclk_i = 1'b0;
  logic       ss_n_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic       lsbfe_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_load_i = 1'b0;
  logic       tx_ready_o, rx_valid_o, miso_o, miso_oe_o, busy_o, underrun_o;
  logic [7:0] rx_data_o;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack_i = 1'b0;
  logic       rx_overrun_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0;
  int und_cnt = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  spi_slave_shifter dut (
    .pclk(pclk), .preset(preset), .sclk_i(sclk_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
    .tx_data_i(tx_data_i), .tx_load_i(tx_load_i),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_ack_i(rx_ack_i), .rx_overrun_o(rx_overrun_o),
`endif
    .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .busy_o(busy_o), .underrun_o(underrun_o)
  );

  always #5 pclk = ~pclk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data_i = d;
    tx_load_i = 1'b1;
    tick(1);
    tx_load_i = 1'b0;
  endtask

  // SCLK half period of 5 pclk; MISO is read by the master at its own sample edge.
  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int pos;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      pos = lsbfe_i ? i : 7 - i;
      if (!cpha_i) begin
        mosi_i = mo[pos];
        tick(5);
        sclk_i = ~cpol_i;
        mi[pos] = miso_o;
        tick(5);
        sclk_i = cpol_i;
      end else begin
        sclk_i = ~cpol_i;
        mosi_i = mo[pos];
        tick(5);
        sclk_i = cpol_i;
        mi[pos] = miso_o;
        tick(5);
      end
    end
  endtask

  task automatic frame(input logic c_pol, input logic c_pha, input logic lsb, input int nbytes,
                       input logic [7:0] mo0, input logic [7:0] mo1,
                       input logic [7:0] ex0, input logic [7:0] ex1);
    logic [7:0] got;
    cpol_i = c_pol; cpha_i = c_pha; lsbfe_i = lsb;
    sclk_i = c_pol;
    tick(4);
    ss_n_i = 1'b0;
    tick(6);
    check_value("oe_in_frame", miso_oe_o, 1);
    check_value("busy_in_frame", busy_o, 1);
    for (int b = 0; b < nbytes; b++) begin
      exp_rx_q.push_back(b == 0 ? mo0 : mo1);
      exp_miso_q.push_back(b == 0 ? ex0 : ex1);
      xfer_bits(b == 0 ? mo0 : mo1, 8, got);
      check_value("miso_byte", got, exp_miso_q.pop_front());
    end
    tick(5);
    ss_n_i = 1'b1;
    tick(8);
  endtask

  always @(negedge pclk) begin
    if (!preset) begin
      if (underrun_o) und_cnt++;
      if (rx_valid_o) begin
        rx_cnt++;
        check_value("rx_expected", exp_rx_q.size() != 0, 1);
        if (exp_rx_q.size() != 0) check_value("rx_data", rx_data_o, exp_rx_q.pop_front());
      end
    end
  end

  initial begin
    int r0, u0;
    logic [7:0] got;

    tick(3);
    check_value("rst_tx_ready", tx_ready_o, 1);
    check_value("rst_rx_valid", rx_valid_o, 0);
    check_value("rst_rx_data", rx_data_o, 0);
    check_value("rst_miso", miso_o, 0);
    check_value("rst_miso_oe", miso_oe_o, 0);
    check_value("rst_busy", busy_o, 0);
    check_value("rst_underrun", underrun_o, 0);
    preset = 1'b0;
    tick(3);

    // Mode 0, MSB first
    load_tx(8'hA5);
    check_value("tx_ready_after_load", tx_ready_o, 0);
    r0 = rx_cnt;
    frame(1'b0, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 8'hA5, 8'h00);
    check_value("m0_rx_pulses", rx_cnt - r0, 1);
    check_value("m0_tx_ready", tx_ready_o, 1);
    check_value("m0_busy_after", busy_o, 0);
    check_value("m0_oe_after", miso_oe_o, 0);

    // Modes 1..3, LSB first
    for (int m = 1; m < 4; m++) begin
      load_tx(8'h7E);
      r0 = rx_cnt;
      frame(m[1], m[0], 1'b1, 1, 8'h81, 8'h00, 8'h7E, 8'h00);
      check_value("lsb_rx_pulses", rx_cnt - r0, 1);
    end

    // Back-to-back bytes with no second load (mode 3)
    load_tx(8'h5A);
    r0 = rx_cnt;
    u0 = und_cnt;
    frame(1'b1, 1'b1, 1'b0, 2, 8'h12, 8'h34, 8'h5A, 8'hFF);
    check_value("b2b_rx_pulses", rx_cnt - r0, 2);
    check_value("b2b_underruns", und_cnt - u0, 1);

    // Abort after 5 SCLKs, then a clean frame
    load_tx(8'hC3);
    cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0; sclk_i = 1'b0;
    tick(4);
    r0 = rx_cnt;
    ss_n_i = 1'b0;
    tick(6);
    xfer_bits(8'hAA, 5, got);
    tick(3);
    ss_n_i = 1'b1;
    tick(6);
    check_value("abort_rx_pulses", rx_cnt - r0, 0);
    check_value("abort_busy", busy_o, 0);
    check_value("abort_oe", miso_oe_o, 0);
    load_tx(8'h69);
    r0 = rx_cnt;
    frame(1'b0, 1'b0, 1'b0, 1, 8'h96, 8'h00, 8'h69, 8'h00);
    check_value("post_abort_pulses", rx_cnt - r0, 1);

    // Asynchronous reset in the middle of a byte
    load_tx(8'h11);
    ss_n_i = 1'b0;
    tick(6);
    xfer_bits(8'hF0, 3, got);
    #2 preset = 1'b1;
    #1;
    check_value("arst_busy", busy_o, 0);
    check_value("arst_oe", miso_oe_o, 0);
    check_value("arst_tx_ready", tx_ready_o, 1);
    check_value("arst_rx_data", rx_data_o, 0);
    tick(2);
    ss_n_i = 1'b1;
    sclk_i = 1'b0;
    preset = 1'b0;
    tick(6);
    check_value("arst_idle_busy", busy_o, 0);
    load_tx(8'hC3);
    frame(1'b0, 1'b0, 1'b0, 1, 8'h5A, 8'h00, 8'hC3, 8'h00);

`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack_i = 1'b1;
    tick(1);
    rx_ack_i = 1'b0;
    check_value("ovr_cleared", rx_overrun_o, 0);
    frame(1'b0, 1'b0, 1'b0, 2, 8'h01, 8'h02, 8'hFF, 8'hFF);
    check_value("ovr_set", rx_overrun_o, 1);
    rx_ack_i = 1'b1;
    tick(1);
    rx_ack_i = 1'b0;
    check_value("ovr_ack", rx_overrun_o, 0);
`endif

    tick(4);
    check_value("rx_queue_drained", exp_rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
- SPI responder (slave-side) shift engine: the far end of the APB SPI master's slave-select/shift logic, for loopback benches and for SoCs acting as SPI peripherals.
- Samples external SCLK/SS_N/MOSI in the pclk domain, deserialises MOSI bytes and serialises a one-byte TX holding buffer onto MISO.
- Supports all four CPOL/CPHA modes and MSB/LSB-first order.

Parameters:
- DATA_W, 8, frame width in bits (bit counter is $clog2(DATA_W)+1 wide).
- UNDERRUN_VAL, 8'hFF, byte shifted out when the TX buffer is empty at a frame/byte boundary.

Ports:
- pclk  input  1  system clock; all logic on posedge.
- preset  input  1  asynchronous active-high reset.
- sclk_i  input  1  SPI clock from master (asynchronous).
- ss_n_i  input  1  slave select, active low (asynchronous).
- mosi_i  input  1  serial data from master.
- cpol_i  input  1  clock idle level.
- cpha_i  input  1  0: sample on leading edge; 1: sample on trailing edge.
- lsbfe_i  input  1  1: LSB first.
- tx_data_i  input  DATA_W  byte to transmit.
- tx_load_i  input  1  write strobe for the TX buffer.
- tx_ready_o  output  1  TX buffer empty; can accept tx_load_i.
- rx_data_o  output  DATA_W  last complete received byte.
- rx_valid_o  output  1  one-pclk pulse when rx_data_o updates.
- miso_o  output  1  serial data to master.
- miso_oe_o  output  1  MISO output enable (high only while selected).
- busy_o  output  1  frame in progress.
- underrun_o  output  1  one-pclk pulse when UNDERRUN_VAL is loaded.

Behaviour:
- Reset (preset high, async): FSM=IDLE, shift regs=0, bit count=0, rx_data_o=0, rx_valid_o=0, tx_ready_o=1, miso_o=0, miso_oe_o=0, busy_o=0, underrun_o=0.
- Synchronisers: sclk_i, ss_n_i and mosi_i each pass through 2 flops. A third sclk flop gives rise/fall detect.
- Input-to-internal latency is 2 pclk. SCLK high and low times must each be ≥4 pclk.
- Leading edge = transition away from the CPOL level; trailing edge = transition back to it.
- sample_edge = cpha ? trailing : leading; shift_edge = the other edge.
- cpol/cpha/lsbfe are captured at SS assertion. Changes mid-frame are ignored.
- FSM IDLE:
  - On synced ss_n falling: go to LOAD.
  - Otherwise miso_oe_o=0 and busy_o=0.
- FSM LOAD (1 cycle):
  - TX shift reg <= TX buffer if full (then tx_ready_o <= 1); else UNDERRUN_VAL with underrun_o pulse.
  - Bit count <= 0; miso_oe_o <= 1; busy_o <= 1.
  - MISO presents the first bit (MSB, or LSB if lsbfe). For CPHA=0 this bit is valid before the first leading edge.
  - Go to SHIFT.
- FSM SHIFT:
  - On sample_edge: capture synced MOSI into the RX shift reg (MSB- or LSB-first insertion) and increment bit count.
  - On shift_edge: advance MISO to the next TX bit. For CPHA=1 the first shift_edge presents bit 0.
  - When bit count reaches DATA_W on a sample_edge:
    - rx_data_o <= assembled byte; rx_valid_o pulses for 1 pclk.
    - Bit count <= 0; TX shift reg reloads as in LOAD, for back-to-back bytes under continuous SS.
- SS deassert:
  - Synced ss_n high in any state → IDLE next cycle; miso_oe_o=0, busy_o=0.
  - Mid-byte: partial RX bits are discarded, no rx_valid_o, the TX buffer is kept, the bit count is cleared.
- TX buffer:
  - tx_load_i with tx_ready_o=1 writes the buffer; tx_ready_o drops the next cycle.
  - tx_load_i with tx_ready_o=0 is ignored.
  - Buffer emptied on the same cycle as a LOAD reload: the reload takes the old contents, and tx_load_i on that cycle is ignored.
- The RX byte boundary and an SS rise in the same cycle: rx_valid_o still pulses, then IDLE.

Optional Feature:
- Macro SPI_SLAVE_OVERRUN_EN.
- Defined:
  - Adds input rx_ack_i (1) and output rx_overrun_o (1).
  - rx_ack_i clears an internal "unread" flag.
  - A byte completing while unread=1 sets rx_overrun_o sticky high. rx_data_o is still overwritten.
  - rx_overrun_o clears on rx_ack_i or preset. If rx_ack_i and a byte completion coincide, unread stays 1 and overrun is not set.
- Undefined: neither port exists; rx_data_o is overwritten silently.

Test Plan:
- Reset: assert preset mid-SHIFT → all outputs at reset values asynchronously, FSM=IDLE after release.
- Mode 0 MSB-first:
  - Stimulus: tx_data_i=8'hA5 loaded, master sends 8'h3C at SCLK=pclk/10.
  - Response: rx_data_o=8'h3C with one rx_valid_o pulse; MISO bits 1,0,1,0,0,1,0,1; tx_ready_o=1 after LOAD.
- Modes 1/2/3 with lsbfe=1: master sends 8'h81, TX 8'h7E → rx_data_o=8'h81, MISO 0,1,1,1,1,1,1,0 on the correct edges.
- Underrun and back-to-back:
  - Stimulus: two bytes under one SS with no second load.
  - Response: second MISO byte = 8'hFF, underrun_o pulses once, two rx_valid_o pulses.
- Abort: SS rises after 5 SCLKs → no rx_valid_o, busy_o=0, miso_oe_o=0; the next full frame receives correctly.
- Overrun (SPI_SLAVE_OVERRUN_EN): two bytes without rx_ack_i → rx_overrun_o=1 after the second; rx_ack_i → 0.
